timer_control: RTL and testbench

TIMER_CONTROL -- requirements
Module: timer_control

---
 rtl/timer_pkg.sv | 104 ++++++++++
 rtl/tick_gen.sv | 28 ++
 rtl/timer_control.sv | 176 +++++++++++++++++
 tb/tb_timer_control.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types, digit limits and BCD time arithmetic for the countdown timer.
package timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned MIN_MAX = 99;
    localparam int unsigned SEC_MAX = 59;

    localparam logic [DIGIT_W-1:0] MIN_MAX_TENS = DIGIT_W'(MIN_MAX / 10);
    localparam logic [DIGIT_W-1:0] MIN_MAX_ONES = DIGIT_W'(MIN_MAX % 10);
    localparam logic [DIGIT_W-1:0] SEC_MAX_TENS = DIGIT_W'(SEC_MAX / 10);
    localparam logic [DIGIT_W-1:0] SEC_MAX_ONES = DIGIT_W'(SEC_MAX % 10);
    localparam logic [DIGIT_W-1:0] BCD_MAX      = DIGIT_W'(9);

    // Button bit positions inside the packed button vectors.
    localparam int unsigned BTN_W       = 5;
    localparam int unsigned BTN_INC_SEC = 0;
    localparam int unsigned BTN_INC_MIN = 1;
    localparam int unsigned BTN_START   = 2;
    localparam int unsigned BTN_STOP    = 3;
    localparam int unsigned BTN_CLEAR   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE    = 3'd0,
        ACT_CLEAR   = 3'd1,
        ACT_STOP    = 3'd2,
        ACT_START   = 3'd3,
        ACT_INC_MIN = 3'd4,
        ACT_INC_SEC = 3'd5
    } action_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] min_10s;
        logic [DIGIT_W-1:0] min_1s;
        logic [DIGIT_W-1:0] sec_10s;
        logic [DIGIT_W-1:0] sec_1s;
    } time_t;

    function automatic logic time_is_zero(input time_t t);
        return (t == '0);
    endfunction

    // Minutes step 00..99 and wrap; seconds untouched.
    function automatic time_t time_inc_min(input time_t t);
        time_t r;
        r = t;
        if (t.min_10s == MIN_MAX_TENS && t.min_1s == MIN_MAX_ONES) begin
            r.min_10s = '0;
            r.min_1s  = '0;
        end else if (t.min_1s == BCD_MAX) begin
            r.min_1s  = '0;
            r.min_10s = t.min_10s + DIGIT_W'(1);
        end else begin
            r.min_1s  = t.min_1s + DIGIT_W'(1);
        end
        return r;
    endfunction

    // Seconds step 00..59 and wrap without carrying into minutes.
    function automatic time_t time_inc_sec(input time_t t);
        time_t r;
        r = t;
        if (t.sec_10s == SEC_MAX_TENS && t.sec_1s == SEC_MAX_ONES) begin
            r.sec_10s = '0;
            r.sec_1s  = '0;
        end else if (t.sec_1s == BCD_MAX) begin
            r.sec_1s  = '0;
            r.sec_10s = t.sec_10s + DIGIT_W'(1);
        end else begin
            r.sec_1s  = t.sec_1s + DIGIT_W'(1);
        end
        return r;
    endfunction

    // One-second countdown with BCD borrows; never applied to 00:00.
    function automatic time_t time_dec(input time_t t);
        time_t r;
        r = t;
        if (t.sec_1s != '0) begin
            r.sec_1s = t.sec_1s - DIGIT_W'(1);
        end else begin
            r.sec_1s = SEC_MAX_ONES;
            if (t.sec_10s != '0) begin
                r.sec_10s = t.sec_10s - DIGIT_W'(1);
            end else begin
                r.sec_10s = SEC_MAX_TENS;
                if (t.min_1s != '0) begin
                    r.min_1s = t.min_1s - DIGIT_W'(1);
                end else begin
                    r.min_1s  = BCD_MAX;
                    r.min_10s = t.min_10s - DIGIT_W'(1);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled, ticks on the terminal count.
module tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned       CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tick_c = i_en && (r_cnt == TERM);

    // Clear outranks enable; a disabled counter holds its value.
    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/timer_control.sv
// MM:SS countdown timer with button control and BCD outputs.
// Optional DONE-state display blink enabled by defining TIMER_BLINK_EN.
module timer_control
    import timer_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    input  logic               btn_start,
    input  logic               btn_stop,
    input  logic               btn_clear,
    input  logic               btn_inc_min,
    input  logic               btn_inc_sec,
    output logic [DIGIT_W-1:0] min_10s,
    output logic [DIGIT_W-1:0] min_1s,
    output logic [DIGIT_W-1:0] sec_10s,
    output logic [DIGIT_W-1:0] sec_1s,
    output logic               running,
    output logic               done,
    output logic               blank
);

    logic [BTN_W-1:0] w_btn;
    logic [BTN_W-1:0] r_btn_q;
    logic [BTN_W-1:0] r_btn_edge;

    state_t  r_state;
    state_t  w_state_nxt;
    time_t   r_time;
    time_t   w_time_nxt;
    time_t   w_time_dec;
    action_t w_act;
    logic    w_tick;
    logic    w_pre_en;
    logic    w_pre_clr;
    logic    r_running;
    logic    r_done;

    assign w_btn = {btn_clear, btn_stop, btn_start, btn_inc_min, btn_inc_sec};

    // Registered rising-edge pulses; the FSM acts on them one cycle later.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_btn_q    <= '0;
            r_btn_edge <= '0;
        end else begin
            r_btn_q    <= w_btn;
            r_btn_edge <= w_btn & ~r_btn_q;
        end
    end

    // Only the highest-priority coincident edge is acted on.
    always_comb begin
        w_act = ACT_NONE;
        if (r_btn_edge[BTN_CLEAR])        w_act = ACT_CLEAR;
        else if (r_btn_edge[BTN_STOP])    w_act = ACT_STOP;
        else if (r_btn_edge[BTN_START])   w_act = ACT_START;
        else if (r_btn_edge[BTN_INC_MIN]) w_act = ACT_INC_MIN;
        else if (r_btn_edge[BTN_INC_SEC]) w_act = ACT_INC_SEC;
    end

    assign w_pre_en = (r_state == ST_RUN);

    tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_tick_gen (
        .clk      (clk_100MHz),
        .reset    (reset),
        .i_en     (w_pre_en),
        .i_clr    (w_pre_clr),
        .o_tick_c (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_pre_clr   = 1'b0;
        w_time_dec  = time_dec(r_time);
        if (w_act == ACT_CLEAR) begin
            w_state_nxt = ST_IDLE;
            w_time_nxt  = '0;
            w_pre_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE, ST_PAUSE: begin
                    case (w_act)
                        ACT_START: begin
                            if (!time_is_zero(r_time)) begin
                                w_state_nxt = ST_RUN;
                                // Resuming from PAUSE keeps the partial second.
                                w_pre_clr   = (r_state == ST_IDLE);
                            end
                        end
                        ACT_INC_MIN: w_time_nxt = time_inc_min(r_time);
                        ACT_INC_SEC: w_time_nxt = time_inc_sec(r_time);
                        default: ;
                    endcase
                end
                ST_RUN: begin
                    // A tick coinciding with stop is applied before pausing.
                    if (w_tick) begin
                        w_time_nxt = w_time_dec;
                    end
                    if (w_tick && time_is_zero(w_time_dec)) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_act == ACT_STOP) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (w_act == ACT_START) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_time    <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_time    <= w_time_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_done    <= (w_state_nxt == ST_DONE);
        end
    end

    assign min_10s = r_time.min_10s;
    assign min_1s  = r_time.min_1s;
    assign sec_10s = r_time.sec_10s;
    assign sec_1s  = r_time.sec_1s;
    assign running = r_running;
    assign done    = r_done;

`ifdef TIMER_BLINK_EN
    localparam int unsigned      BLINK_HALF = TICKS_PER_SEC / 2;
    localparam int unsigned      BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_TERM = BLINK_W'(BLINK_HALF - 1);

    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blank;

    // Blank starts high on DONE entry and toggles every half second while in DONE.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end else if (w_state_nxt == ST_DONE) begin
            if (r_state != ST_DONE) begin
                r_blink_cnt <= '0;
                r_blank     <= 1'b1;
            end else if (r_blink_cnt == BLINK_TERM) begin
                r_blink_cnt <= '0;
                r_blank     <= ~r_blank;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end else begin
            r_blink_cnt <= '0;
            r_blank     <= 1'b0;
        end
    end

    assign blank = r_blank;
`else
    assign blank = 1'b0;
`endif

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control at TICKS_PER_SEC=10: directed table, corner sequences, random vs. model.
module tb_timer_control;

    localparam int T = 10;
    localparam logic [4:0] B_SEC   = 5'b00001;
    localparam logic [4:0] B_MIN   = 5'b00010;
    localparam logic [4:0] B_START = 5'b00100;
    localparam logic [4:0] B_STOP  = 5'b01000;
    localparam logic [4:0] B_CLR   = 5'b10000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_start, btn_stop, btn_clear, btn_inc_min, btn_inc_sec;
    logic [3:0] min_10s, min_1s, sec_10s, sec_1s;
    logic       running, done, blank;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: whole minutes/seconds, cycles spent in DONE.
    int         m_state, m_min, m_sec, m_pre, m_done_n;
    logic [4:0] m_prev, m_edge;

    always #5 clk = ~clk;

    timer_control #(.TICKS_PER_SEC(T)) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_clear  (btn_clear),
        .btn_inc_min(btn_inc_min),
        .btn_inc_sec(btn_inc_sec),
        .min_10s    (min_10s),
        .min_1s     (min_1s),
        .sec_10s    (sec_10s),
        .sec_1s     (sec_1s),
        .running    (running),
        .done       (done),
        .blank      (blank)
    );

    function automatic logic [18:0] dut_vec();
        return {min_10s, min_1s, sec_10s, sec_1s, running, done, blank};
    endfunction

    function automatic void check(input string name, input logic [18:0] got, input logic [18:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h required %05h (time=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_state = S_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_done_n = 0;
        m_prev = '0; m_edge = '0;
    endfunction

    // One clock edge of the behavioural timer; b is the button level sampled at that edge.
    function automatic void model_step(input logic [4:0] b, input logic rst);
        logic [4:0] e;
        bit         tick;
        int         prev, tot;
        if (rst) begin
            model_reset();
            return;
        end
        e      = m_edge;
        m_edge = b & ~m_prev;
        m_prev = b;
        prev   = m_state;
        tick   = (m_state == S_RUN) && (m_pre == T - 1);
        if (m_state == S_RUN) m_pre = (m_pre + 1) % T;
        tot = m_min * 60 + m_sec;
        if (e[4]) begin
            m_state = S_IDLE; m_min = 0; m_sec = 0; m_pre = 0;
        end else if (m_state == S_RUN) begin
            if (tick) begin
                tot   = tot - 1;
                m_min = tot / 60;
                m_sec = tot % 60;
            end
            if (tick && tot == 0) m_state = S_DONE;
            else if (e[3])        m_state = S_PAUSE;
        end else if (m_state == S_DONE) begin
            if (!e[3] && e[2]) m_state = S_IDLE;
        end else if (!e[3]) begin
            if (e[2]) begin
                if (tot != 0) begin
                    if (m_state == S_IDLE) m_pre = 0;
                    m_state = S_RUN;
                end
            end else if (e[1]) begin
                m_min = (m_min + 1) % 100;
            end else if (e[0]) begin
                m_sec = (m_sec + 1) % 60;
            end
        end
        if (m_state == S_DONE) m_done_n = (prev == S_DONE) ? m_done_n + 1 : 0;
    endfunction

    function automatic logic [18:0] model_vec();
        logic bl;
        bl = 1'b0;
`ifdef TIMER_BLINK_EN
        bl = (m_state == S_DONE) && (((m_done_n / (T / 2)) % 2) == 0);
`endif
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
                m_state == S_RUN, m_state == S_DONE, bl};
    endfunction

    task automatic cycle(input logic [4:0] b, input logic rst);
        logic [18:0] got;
        {btn_clear, btn_stop, btn_start, btn_inc_min, btn_inc_sec} = b;
        reset = rst;
        @(posedge clk);
        model_step(b, rst);
        @(negedge clk);
        got = dut_vec();
        check("model", got, model_vec());
        n_tests++;
        if (got[18:15] > 4'd9 || got[14:11] > 4'd9 || got[10:7] > 4'd5 || got[6:3] > 4'd9) begin
            n_fail++;
            $display("FAIL bcd_legal: got digits %04h required BCD with sec_10s<=5", got[18:3]);
        end
    endtask

    task automatic press(input logic [4:0] b);
        cycle(b, 1'b0);
        cycle(5'b0, 1'b0);
    endtask

    // Directed table: buttons held for n cycles, then time/running/done compared.
    task automatic check_tm(input string name, input logic [15:0] t, input logic r, input logic d);
        logic [18:0] got;
        got    = dut_vec();
        got[0] = 1'b0;
        check(name, got, {t, r, d, 1'b0});
    endtask

    typedef struct {
        logic [4:0]  btn;
        int          cycles;
        logic [15:0] exp_time;
        logic        exp_run;
        logic        exp_done;
        string       name;
    } vec_t;

    vec_t tbl[26];

    initial begin
        tbl[0]  = '{B_MIN,          1, 16'h0000, 1'b0, 1'b0, "edge_latency"};
        tbl[1]  = '{5'b0,           1, 16'h0100, 1'b0, 1'b0, "inc_min_1"};
        tbl[2]  = '{B_MIN,          1, 16'h0100, 1'b0, 1'b0, "inc_min_2a"};
        tbl[3]  = '{5'b0,           1, 16'h0200, 1'b0, 1'b0, "inc_min_2"};
        tbl[4]  = '{B_SEC,          1, 16'h0200, 1'b0, 1'b0, "inc_sec_1a"};
        tbl[5]  = '{5'b0,           1, 16'h0201, 1'b0, 1'b0, "inc_sec_1"};
        tbl[6]  = '{B_SEC,          1, 16'h0201, 1'b0, 1'b0, "inc_sec_2a"};
        tbl[7]  = '{5'b0,           1, 16'h0202, 1'b0, 1'b0, "inc_sec_2"};
        tbl[8]  = '{B_SEC,          5, 16'h0203, 1'b0, 1'b0, "held_acts_once"};
        tbl[9]  = '{5'b0,           1, 16'h0203, 1'b0, 1'b0, "digits_0203"};
        tbl[10] = '{B_MIN | B_SEC,  1, 16'h0203, 1'b0, 1'b0, "prio_min_sec_a"};
        tbl[11] = '{5'b0,           1, 16'h0303, 1'b0, 1'b0, "prio_min_over_sec"};
        tbl[12] = '{B_STOP|B_START, 1, 16'h0303, 1'b0, 1'b0, "prio_stop_start_a"};
        tbl[13] = '{5'b0,           2, 16'h0303, 1'b0, 1'b0, "prio_stop_over_start"};
        tbl[14] = '{B_CLR | B_MIN,  1, 16'h0303, 1'b0, 1'b0, "clear_a"};
        tbl[15] = '{5'b0,           1, 16'h0000, 1'b0, 1'b0, "clear_over_min"};
        tbl[16] = '{B_MIN,          1, 16'h0000, 1'b0, 1'b0, "set_0100_a"};
        tbl[17] = '{5'b0,           1, 16'h0100, 1'b0, 1'b0, "set_0100"};
        tbl[18] = '{B_START,        1, 16'h0100, 1'b0, 1'b0, "start_a"};
        tbl[19] = '{5'b0,           1, 16'h0100, 1'b1, 1'b0, "run_entry"};
        tbl[20] = '{5'b0,           9, 16'h0100, 1'b1, 1'b0, "before_first_tick"};
        tbl[21] = '{5'b0,           1, 16'h0059, 1'b1, 1'b0, "first_tick_0059"};
        tbl[22] = '{5'b0,         589, 16'h0001, 1'b1, 1'b0, "last_second"};
        tbl[23] = '{5'b0,           1, 16'h0000, 1'b0, 1'b1, "done_reached"};
        tbl[24] = '{B_START,        1, 16'h0000, 1'b0, 1'b1, "done_start_a"};
        tbl[25] = '{5'b0,           1, 16'h0000, 1'b0, 1'b0, "done_start_idle"};
    end

    initial begin
        logic [4:0] cur;
        model_reset();
        cycle(5'b0, 1'b1);
        cycle(5'b0, 1'b1);
        check("reset_state", dut_vec(), 19'h0);
        cycle(5'b0, 1'b0);

        for (int i = 0; i < 26; i++) begin
            for (int c = 0; c < tbl[i].cycles; c++) cycle(tbl[i].btn, 1'b0);
            check_tm(tbl[i].name, tbl[i].exp_time, tbl[i].exp_run, tbl[i].exp_done);
        end

        // Start at 00:00 is ignored.
        press(B_START);
        cycle(5'b0, 1'b0);
        check_tm("start_at_zero", 16'h0000, 1'b0, 1'b0);

        // Stop on the tick cycle: tick applied, then PAUSE with the prescaler wrapped.
        for (int i = 0; i < 5; i++) press(B_SEC);
        check_tm("set_0005", 16'h0005, 1'b0, 1'b0);
        cycle(B_START, 1'b0);
        for (int i = 0; i < 9; i++) cycle(5'b0, 1'b0);
        cycle(B_STOP, 1'b0);
        cycle(5'b0, 1'b0);
        check_tm("stop_on_tick", 16'h0004, 1'b0, 1'b0);
        press(B_START);
        check_tm("resume", 16'h0004, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) cycle(5'b0, 1'b0);
        check_tm("resume_no_early_tick", 16'h0004, 1'b1, 1'b0);
        cycle(5'b0, 1'b0);
        check_tm("resume_tick", 16'h0003, 1'b1, 1'b0);

        // Clear and start together while running.
        press(B_CLR | B_START);
        check_tm("clear_start_in_run", 16'h0000, 1'b0, 1'b0);

        // Reset on the cycle a tick is due discards it.
        press(B_SEC);
        press(B_SEC);
        press(B_START);
        for (int i = 0; i < 9; i++) cycle(5'b0, 1'b0);
        cycle(5'b0, 1'b1);
        check("reset_mid_run", dut_vec(), 19'h0);
        for (int i = 0; i < 12; i++) cycle(5'b0, 1'b0);
        check_tm("after_reset_idle", 16'h0000, 1'b0, 1'b0);

        // Minute and second wrap.
        for (int i = 0; i < 99; i++) press(B_MIN);
        check_tm("min_99", 16'h9900, 1'b0, 1'b0);
        press(B_MIN);
        check_tm("min_wrap", 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) press(B_SEC);
        check_tm("sec_59", 16'h0059, 1'b0, 1'b0);
        press(B_SEC);
        check_tm("sec_wrap_no_carry", 16'h0000, 1'b0, 1'b0);

        // Randomized buttons with held levels, checked cycle by cycle against the model.
        cur = '0;
        for (int i = 0; i < 15000; i++) begin
            logic rst;
            if ($urandom_range(0, 3) == 0) begin
                cur = '0;
                if ($urandom_range(0, 99) < 2)  cur = cur | B_CLR;
                if ($urandom_range(0, 99) < 8)  cur = cur | B_STOP;
                if ($urandom_range(0, 99) < 20) cur = cur | B_START;
                if ($urandom_range(0, 99) < 25) cur = cur | B_MIN;
                if ($urandom_range(0, 99) < 25) cur = cur | B_SEC;
            end
            rst = ($urandom_range(0, 2999) == 0);
            cycle(cur, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
